// File: rtl/mux_nx1_rr_collector.sv
// rtl/mux_nx1_rr_collector.sv - registered N-to-1 round-robin collector with valid/ready handshakes
module mux_nx1_rr_collector #(
  parameter int N     = 8,
  parameter int SEL   = 3,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL-1:0]     out_sel,
  input  logic               out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [SEL:0] N_W = (SEL+1)'(N);

  state_t           state;
  logic [SEL-1:0]   ptr;
  logic             load_en;
  logic             grant_found;
  logic [SEL-1:0]   grant_idx;
  logic [SEL:0]     sum;
  logic [SEL-1:0]   idx_w;
  logic [N-1:0]     in_ready_c;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;

  assign load_en   = (state == EMPTY) || out_ready;
  assign out_valid = (state == FULL);

  // Round-robin search: first requester strictly after the last grant, wrapping at N-1
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    idx_w       = '0;
    for (int k = 1; k <= N; k++) begin
      sum   = {1'b0, ptr} + (SEL+1)'(k);
      idx_w = (sum >= N_W) ? SEL'(sum - N_W) : SEL'(sum);
      if (!grant_found && in_valid[idx_w]) begin
        grant_found = 1'b1;
        grant_idx   = idx_w;
      end
    end
  end

  // One-hot accept strobe, suppressed during reset and while the output register is stalled
  always_comb begin
    in_ready_c = '0;
    if (rst_n && load_en && grant_found) begin
      in_ready_c[grant_idx] = 1'b1;
    end
  end

  assign in_ready = in_ready_c;
  assign xfer     = |in_ready_c;

  // Select the winning channel's data word
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SEL'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register FSM: state mirrors out_valid, pointer moves only on a transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      ptr      <= SEL'(N-1);
    end else begin
      case (state)
        EMPTY: begin
          if (xfer) begin
            state    <= FULL;
            out_data <= grant_data;
            out_sel  <= grant_idx;
            ptr      <= grant_idx;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (xfer) begin
              out_data <= grant_data;
              out_sel  <= grant_idx;
              ptr      <= grant_idx;
            end else begin
              state <= EMPTY;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_nx1_rr_collector.sv
// tb/tb_mux_nx1_rr_collector.sv - self-checking bench for mux_nx1_rr_collector
module tb_mux_nx1_rr_collector;

  localparam int N     = 8;
  localparam int SEL   = 3;
  localparam int WIDTH = 8;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SEL-1:0]     out_sel;
  logic               out_ready;

  mux_nx1_rr_collector #(.N(N), .SEL(SEL), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: plain integers
  int m_valid = 0;
  int m_data  = 0;
  int m_sel   = 0;
  int m_ptr   = N-1;
  int m_fresh = 0;
  logic [N-1:0] rdy_seen;

  typedef struct {
    logic        rstn;
    logic [7:0]  v;
    logic [63:0] d;
    logic        ordy;
    logic [7:0]  exp_rdy;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [2:0]  exp_sel;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_rdy(input logic r, input logic [N-1:0] v, input logic o);
    logic [N-1:0] res;
    res = '0;
    if (r && (m_valid == 0 || o)) begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + 1 + i) % N;
        if (res == 0 && v[c]) res[c] = 1'b1;
      end
    end
    return res;
  endfunction

  // one clock: drive, check accept strobe, clock edge, check registered outputs
  task automatic cycle(input logic r, input logic [N-1:0] v, input logic [63:0] d, input logic o);
    logic [N-1:0] exp_rdy;
    rst_n = r; in_valid = v; in_data = d; out_ready = o;
    #2;
    exp_rdy  = model_rdy(r, v, o);
    rdy_seen = in_ready;
    chk("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    if (!r) begin
      m_valid = 0; m_data = 0; m_sel = 0; m_ptr = N-1; m_fresh = 1;
    end else if (exp_rdy != 0) begin
      for (int g = 0; g < N; g++) begin
        if (exp_rdy[g]) begin
          m_valid = 1; m_data = int'(d[g*WIDTH +: WIDTH]); m_sel = g; m_ptr = g; m_fresh = 0;
        end
      end
    end else if (o) begin
      m_valid = 0;
    end
    #1;
    chk("out_valid", out_valid, m_valid[0]);
    if (m_valid != 0 || m_fresh != 0) begin
      chk("out_data", out_data, m_data[7:0]);
      chk("out_sel", out_sel, m_sel[2:0]);
    end
  endtask

  localparam logic [63:0] DIDX = 64'h0706050403020100;
  localparam logic [63:0] DA5  = 64'h0000000000A50000;

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    // reset with all requests asserted
    tbl.push_back('{1'b0, 8'hFF, DIDX, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0});
    tbl.push_back('{1'b0, 8'hFF, DIDX, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0});
    // single source
    tbl.push_back('{1'b1, 8'h04, DA5,  1'b1, 8'h04, 1'b1, 8'hA5, 3'd2});
    // re-reset then full contention: 0..7, 0
    tbl.push_back('{1'b0, 8'h00, DIDX, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0});
    for (int i = 0; i < 9; i++) begin
      logic [7:0] oh;
      oh = 8'h01 << (i % 8);
      tbl.push_back('{1'b1, 8'hFF, DIDX, 1'b1, oh, 1'b1, 8'(i % 8), 3'(i % 8)});
    end
    // wrap: grant 7, then alternate 0/7
    tbl.push_back('{1'b1, 8'h80, DIDX, 1'b1, 8'h80, 1'b1, 8'h07, 3'd7});
    tbl.push_back('{1'b1, 8'h81, DIDX, 1'b1, 8'h01, 1'b1, 8'h00, 3'd0});
    tbl.push_back('{1'b1, 8'h81, DIDX, 1'b1, 8'h80, 1'b1, 8'h07, 3'd7});
    tbl.push_back('{1'b1, 8'h81, DIDX, 1'b1, 8'h01, 1'b1, 8'h00, 3'd0});
    // backpressure with sel=3 held for 5 cycles, then grant 4
    tbl.push_back('{1'b1, 8'h08, DIDX, 1'b1, 8'h08, 1'b1, 8'h03, 3'd3});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1'b1, 8'hFF, DIDX, 1'b0, 8'h00, 1'b1, 8'h03, 3'd3});
    tbl.push_back('{1'b1, 8'hFF, DIDX, 1'b1, 8'h10, 1'b1, 8'h04, 3'd4});
    // reset mid-operation while stalled, then lowest requester wins
    tbl.push_back('{1'b1, 8'hFF, DIDX, 1'b0, 8'h00, 1'b1, 8'h04, 3'd4});
    tbl.push_back('{1'b0, 8'hFF, DIDX, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0});
    tbl.push_back('{1'b1, 8'h28, DIDX, 1'b0, 8'h08, 1'b1, 8'h03, 3'd3});

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].rstn, tbl[i].v, tbl[i].d, tbl[i].ordy);
      chk($sformatf("vec%0d_rdy", i), rdy_seen, tbl[i].exp_rdy);
      chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid || !tbl[i].rstn) begin
        chk($sformatf("vec%0d_data", i), out_data, tbl[i].exp_data);
        chk($sformatf("vec%0d_sel", i), out_sel, tbl[i].exp_sel);
      end
    end

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic       r;
      logic [7:0] v;
      logic [63:0] d;
      logic       o;
      r = ($urandom_range(0, 59) != 0);
      case ($urandom_range(0, 3))
        0: v = 8'h00;
        1: v = 8'h01 << $urandom_range(0, 7);
        default: v = 8'($urandom);
      endcase
      d = {$urandom, $urandom};
      o = ($urandom_range(0, 3) != 0);
      cycle(r, v, d, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
